// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned WIDTH_DEF = 4;
    localparam int unsigned PW        = 2 * WIDTH_DEF;

    // Product width for an arbitrary operand width
    function automatic int unsigned pw_of(input int unsigned w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used to build ripple-carry rows.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);

    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));

endmodule

// File: rtl/mult_row_add.sv
// One partial-product row: acc +/- (m_ext << shamt) when enabled, ripple-carry across PW bits.
module mult_row_add #(
    parameter int unsigned PW = 8,
    parameter int unsigned SW = $clog2(PW)
) (
    input  logic [PW-1:0] i_acc,
    input  logic [PW-1:0] i_m_ext,
    input  logic [SW-1:0] i_shamt,
    input  logic          i_en,
    input  logic          i_sub,
    output logic [PW-1:0] o_acc
);

    logic [PW-1:0] w_addend;
    logic [PW-1:0] w_b;
    logic [PW-1:0] w_c;
    logic          w_sub;

    assign w_addend = i_en ? (i_m_ext << i_shamt) : '0;
    assign w_sub    = i_en & i_sub;
    // Subtraction is addition of the inverted addend with carry-in 1
    assign w_b      = w_addend ^ {PW{w_sub}};
    assign w_c[0]   = w_sub;

    for (genvar i = 0; i < PW - 1; i++) begin : g_fa
        full_adder u_fa (
            .i_a  (i_acc[i]),
            .i_b  (w_b[i]),
            .i_ci (w_c[i]),
            .o_s  (o_acc[i]),
            .o_co (w_c[i+1])
        );
    end

    // MSB is sum-only: the carry out of the product width is discarded
    assign o_acc[PW-1] = i_acc[PW-1] ^ w_b[PW-1] ^ w_c[PW-1];

endmodule

// File: rtl/seq_array_mult.sv
// Sequential shift-add multiplier, one partial-product row per clock, valid/ready on both sides.
// Optional two's-complement mode enabled by defining SIGNED_MODE_EN.
module seq_array_mult
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         m,
    input  logic [WIDTH-1:0]         q,
`ifdef SIGNED_MODE_EN
    input  logic                     op_signed,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [pw_of(WIDTH)-1:0]  p
);

    localparam int unsigned PRODW = pw_of(WIDTH);
    localparam int unsigned CW    = $clog2(WIDTH);
    localparam int unsigned SW    = $clog2(PRODW);

    state_t             r_state, w_state_next;
    logic [WIDTH-1:0]   r_m, w_m_next;
    logic [WIDTH-1:0]   r_q, w_q_next;
    logic [CW-1:0]      r_cnt, w_cnt_next;
    logic [PRODW-1:0]   r_acc, w_acc_next;
    logic [PRODW-1:0]   r_p, w_p_next;
    logic               r_out_valid, w_out_valid_next;
    logic [PRODW-1:0]   w_m_ext;
    logic [PRODW-1:0]   w_row_acc;
    logic               w_sub;
    logic               w_last_row;

    assign w_last_row = (r_cnt == CW'(WIDTH - 1));

`ifdef SIGNED_MODE_EN
    logic r_signed, w_signed_next;

    assign w_m_ext = {{WIDTH{r_signed & r_m[WIDTH-1]}}, r_m};
    // The q MSB carries negative weight in two's complement
    assign w_sub   = r_signed & w_last_row;
`else
    assign w_m_ext = {{WIDTH{1'b0}}, r_m};
    assign w_sub   = 1'b0;
`endif

    mult_row_add #(
        .PW (PRODW),
        .SW (SW)
    ) u_row (
        .i_acc   (r_acc),
        .i_m_ext (w_m_ext),
        .i_shamt (SW'(r_cnt)),
        .i_en    (r_q[r_cnt]),
        .i_sub   (w_sub),
        .o_acc   (w_row_acc)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_m         <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_p         <= '0;
            r_out_valid <= 1'b0;
`ifdef SIGNED_MODE_EN
            r_signed    <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_m         <= w_m_next;
            r_q         <= w_q_next;
            r_cnt       <= w_cnt_next;
            r_acc       <= w_acc_next;
            r_p         <= w_p_next;
            r_out_valid <= w_out_valid_next;
`ifdef SIGNED_MODE_EN
            r_signed    <= w_signed_next;
`endif
        end
    end

    // Next-state and datapath update
    always_comb begin
        w_state_next     = r_state;
        w_m_next         = r_m;
        w_q_next         = r_q;
        w_cnt_next       = r_cnt;
        w_acc_next       = r_acc;
        w_p_next         = r_p;
        w_out_valid_next = r_out_valid;
`ifdef SIGNED_MODE_EN
        w_signed_next    = r_signed;
`endif
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_next = BUSY;
                    w_m_next     = m;
                    w_q_next     = q;
                    w_cnt_next   = '0;
                    w_acc_next   = '0;
`ifdef SIGNED_MODE_EN
                    w_signed_next = op_signed;
`endif
                end
            end
            BUSY: begin
                w_acc_next = w_row_acc;
                w_cnt_next = r_cnt + CW'(1);
                if (w_last_row) begin
                    w_state_next     = DONE;
                    w_cnt_next       = '0;
                    w_p_next         = w_row_acc;
                    w_out_valid_next = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next     = IDLE;
                    w_out_valid_next = 1'b0;
                end
            end
            default: begin
                w_state_next     = IDLE;
                w_out_valid_next = 1'b0;
            end
        endcase
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign p         = r_p;

endmodule

// File: tb/tb_seq_array_mult.sv
// Directed bench for seq_array_mult at WIDTH=4 and WIDTH=8; signed vectors when SIGNED_MODE_EN is defined.
module tb_seq_array_mult;

    logic        clk;
    logic        rst_n;

    logic        in_valid4, in_ready4, out_valid4, out_ready4, sg4;
    logic [3:0]  m4, q4;
    logic [7:0]  p4;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, sg8;
    logic [7:0]  m8, q8;
    logic [15:0] p8;

    int n_vec = 0;
    int n_bad = 0;

    seq_array_mult #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .m         (m4),
        .q         (q4),
`ifdef SIGNED_MODE_EN
        .op_signed (sg4),
`endif
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .p         (p4)
    );

    seq_array_mult #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .m         (m8),
        .q         (q8),
`ifdef SIGNED_MODE_EN
        .op_signed (sg8),
`endif
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .p         (p8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One WIDTH=4 transaction; acceptance on the first posedge, product 4 edges later
    task automatic run4(input string tag, input logic [3:0] mm, input logic [3:0] qq,
                        input logic sg, input logic noise, input logic [7:0] exp);
        @(negedge clk);
        in_valid4 = 1'b1;
        m4 = mm;
        q4 = qq;
        sg4 = sg;
        @(posedge clk);
        @(negedge clk);
        in_valid4 = noise;
        m4 = 4'hF;
        q4 = 4'hF;
        sg4 = ~sg;
        check({tag, "_busy_in_ready"}, 64'(in_ready4), 64'd0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 3) in_valid4 = 1'b0;
        end
        check({tag, "_early_valid"}, 64'(out_valid4), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_valid"}, 64'(out_valid4), 64'd1);
        check({tag, "_p"}, 64'(p4), 64'(exp));
        if (out_ready4) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_idle_ready"}, 64'(in_ready4), 64'd1);
            check({tag, "_idle_valid"}, 64'(out_valid4), 64'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid4 = 1'b0; out_ready4 = 1'b1; sg4 = 1'b0; m4 = '0; q4 = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; sg8 = 1'b0; m8 = '0; q8 = '0;
        #2;
        check("rst_in_ready", 64'(in_ready4), 64'd1);
        check("rst_out_valid", 64'(out_valid4), 64'd0);
        check("rst_p", 64'(p4), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run4("u15x15", 4'd15, 4'd15, 1'b0, 1'b0, 8'hE1);
        run4("u0x9",   4'd0,  4'd9,  1'b0, 1'b1, 8'h00);
        run4("u9x0",   4'd9,  4'd0,  1'b0, 1'b1, 8'h00);
        run4("u6x7",   4'd6,  4'd7,  1'b0, 1'b0, 8'h2A);

        // Backpressure in DONE
        out_ready4 = 1'b0;
        run4("bp13x11", 4'd13, 4'd11, 1'b0, 1'b0, 8'h8F);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_hold_valid", 64'(out_valid4), 64'd1);
            check("bp_hold_p", 64'(p4), 64'h8F);
            check("bp_hold_in_ready", 64'(in_ready4), 64'd0);
        end
        out_ready4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_ready", 64'(in_ready4), 64'd1);
        check("bp_release_valid", 64'(out_valid4), 64'd0);
        check("bp_keep_p", 64'(p4), 64'h8F);

        // Reset mid-BUSY at cnt=2
        @(negedge clk);
        in_valid4 = 1'b1; m4 = 4'd9; q4 = 4'd9;
        @(posedge clk);
        @(negedge clk);
        in_valid4 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy_valid", 64'(out_valid4), 64'd0);
        check("abort_busy_p", 64'(p4), 64'd0);
        check("abort_busy_ready", 64'(in_ready4), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run4("u3x5", 4'd3, 4'd5, 1'b0, 1'b0, 8'h0F);

        // Reset while waiting in DONE
        out_ready4 = 1'b0;
        run4("hold6x7", 4'd6, 4'd7, 1'b0, 1'b0, 8'h2A);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_done_valid", 64'(out_valid4), 64'd0);
        check("abort_done_p", 64'(p4), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready4 = 1'b1;
        run4("u3x5b", 4'd3, 4'd5, 1'b0, 1'b0, 8'h0F);

`ifdef SIGNED_MODE_EN
        run4("s_m8x7",  4'h8, 4'h7, 1'b1, 1'b0, 8'hC8);
        run4("s_m8xm8", 4'h8, 4'h8, 1'b1, 1'b0, 8'h40);
        run4("s_3xm1",  4'h3, 4'hF, 1'b1, 1'b0, 8'hFD);
        run4("u_8x7",   4'h8, 4'h7, 1'b0, 1'b0, 8'h38);
`endif

        // WIDTH=8: 255x255 with 8-edge latency
        @(negedge clk);
        in_valid8 = 1'b1; m8 = 8'hFF; q8 = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0;
        check("w8_busy_ready", 64'(in_ready8), 64'd0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("w8_early_valid", 64'(out_valid8), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("w8_valid", 64'(out_valid8), 64'd1);
        check("w8_p", 64'(p8), 64'hFE01);
        @(posedge clk);
        @(negedge clk);
        check("w8_idle_ready", 64'(in_ready8), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
